ysyx_23060203_rf_scoreboard: RTL and testbench

Parametrised integer register file for the pipelined NPC core, with a per-register busy scoreboard.
- NRD combinational read ports with same-cycle write-to-read bypass; one synchronous write port.
- Busy bits are set at issue, cleared at writeback and cleared by pipeline flush.
- Sits between decode/issue (read and hazard check) and WB (write); x0 hardwired to zero.

---
 rtl/ysyx_23060203_pkg.sv | 18 +
 rtl/ysyx_23060203_rf_rdport.sv | 43 ++++
 rtl/ysyx_23060203_rf_scoreboard.sv | 103 ++++++++++
 tb/tb_ysyx_23060203_rf_scoreboard.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060203_pkg.sv
//------------------------------------------------------------------------------
// Module : ysyx_23060203_pkg
// Brief  : Shared sizing constants for the NPC integer register file.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ysyx_23060203_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_RV32I   = 32;
  localparam int NREG_RV32E   = 16;
  localparam int REG_ZERO     = 0;   // x0: hardwired zero, no storage, no busy bit
  localparam int REG_FIRST    = 1;   // first register with real storage

endpackage

`default_nettype wire

// File: rtl/ysyx_23060203_rf_rdport.sv
//------------------------------------------------------------------------------
// Module : ysyx_23060203_rf_rdport
// Brief  : One combinational read port: x0 force, writeback bypass, busy lookup.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060203_rf_rdport
  import ysyx_23060203_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_RV32I,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]              raddr_i,
  input  logic                       wen_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic [NREG-1:0][XLEN-1:0]  rf_i,
  input  logic [NREG-1:0]            sb_i,
  output logic [XLEN-1:0]            rdata_o,
  output logic                       rbusy_o
);

  always_comb begin
    rdata_o = '0;
    rbusy_o = 1'b0;
    if (raddr_i == AW'(REG_ZERO)) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end else if (wen_i && (waddr_i == raddr_i)) begin
      // Producer is writing back right now, so the source is already resolved.
      rdata_o = wdata_i;
      rbusy_o = 1'b0;
    end else begin
      rdata_o = rf_i[raddr_i];
      rbusy_o = sb_i[raddr_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060203_rf_scoreboard.sv
//------------------------------------------------------------------------------
// Module : ysyx_23060203_rf_scoreboard
// Brief  : Integer register file with per-register busy scoreboard and bypass.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060203_rf_scoreboard
  import ysyx_23060203_pkg::*;
#(
  parameter  int XLEN = XLEN_DEFAULT,
  parameter  int NREG = NREG_RV32I,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*XLEN-1:0]   rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  flush,
  output logic                  any_busy
);

  logic [XLEN-1:0]            rf_q [REG_FIRST:NREG-1];
  logic [NREG-1:REG_FIRST]    sb_q;
  logic [NREG-1:REG_FIRST]    sb_d;
  logic [NREG-1:0][XLEN-1:0]  w_rf_flat;
  logic [NREG-1:0]            w_sb_flat;

  // Register write is independent of flush: the WB-stage instruction is committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = REG_FIRST; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      for (int r = REG_FIRST; r < NREG; r++) begin
        if (wen && (waddr == AW'(r))) begin
          rf_q[r] <= wdata;
        end
      end
    end
  end

  // Flush beats issue; issue beats writeback because the issuing producer is younger.
  always_comb begin
    sb_d = sb_q;
    for (int r = REG_FIRST; r < NREG; r++) begin
      if (flush) begin
        sb_d[r] = 1'b0;
      end else if (iss_valid && (iss_rd == AW'(r))) begin
        sb_d[r] = 1'b1;
      end else if (wen && (waddr == AW'(r))) begin
        sb_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign any_busy = |sb_q;

  // Zero-extended views so read ports can index x0 without special storage.
  assign w_rf_flat[REG_ZERO] = '0;
  assign w_sb_flat[REG_ZERO] = 1'b0;

  for (genvar r = REG_FIRST; r < NREG; r++) begin : g_flat
    assign w_rf_flat[r] = rf_q[r];
    assign w_sb_flat[r] = sb_q[r];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rdport
    ysyx_23060203_rf_rdport #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
    ) u_rdport (
      .raddr_i (raddr[i*AW +: AW]),
      .wen_i   (wen),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .rf_i    (w_rf_flat),
      .sb_i    (w_sb_flat),
      .rdata_o (rdata[i*XLEN +: XLEN]),
      .rbusy_o (rbusy[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060203_rf_scoreboard.sv
//------------------------------------------------------------------------------
// Module : tb_ysyx_23060203_rf_scoreboard
// Brief  : Directed self-checking bench for the register file scoreboard.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060203_rf_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 wen;
  logic [AW-1:0]        waddr;
  logic [XLEN-1:0]      wdata;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 flush;
  logic                 any_busy;

  int n_cmp;
  int n_err;

  ysyx_23060203_rf_scoreboard #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .any_busy  (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); raddr = '0;
    tick(); tick();
    rst_n = 1'b1;
    // some activity before the mid-stream reset
    wen = 1'b1; waddr = 5'd5; wdata = 32'h5555_5555;
    iss_valid = 1'b1; iss_rd = 5'd31;
    tick();
    // reset asserted while a write and an issue are pending
    wen = 1'b1; waddr = 5'd31; wdata = 32'hFFFF_0000;
    iss_valid = 1'b1; iss_rd = 5'd5;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (any_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_any_busy_during: got %0b want 0", any_busy);
    end
    tick(); tick(); tick();
    idle();
    rst_n = 1'b1;
    raddr = {5'd31, 5'd5};
    #1;
    n_cmp++;
    if (rdata !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    n_cmp++;
    if (rbusy !== 2'b00 || any_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got rbusy=%b any=%b want 00/0", rbusy, any_busy);
    end
    tick();
    n_cmp++;
    if (rdata !== 64'h0 || rbusy !== 2'b00 || any_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_after_edge: got rdata=%h rbusy=%b any=%b want 0", rdata, rbusy, any_busy);
    end
  endtask

  task automatic test_write_read();
    idle(); raddr = '0;
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    tick();
    wen = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234;
    tick();
    idle();
    raddr = {5'd0, 5'd5};
    #1;
    n_cmp++;
    if (rdata[31:0] !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL write_x5: got %h want deadbeef", rdata[31:0]);
    end
    n_cmp++;
    if (rdata[63:32] !== 32'h0 || rbusy !== 2'b00) begin
      n_err++; $display("FAIL write_x0_ignored: got %h busy=%b want 0/00", rdata[63:32], rbusy);
    end
    // back-to-back writes to neighbouring registers
    wen = 1'b1; waddr = 5'd1; wdata = 32'h1111_0001;
    tick();
    wen = 1'b1; waddr = 5'd2; wdata = 32'h2222_0002;
    tick();
    idle();
    raddr = {5'd2, 5'd1};
    #1;
    n_cmp++;
    if (rdata !== 64'h2222_0002_1111_0001) begin
      n_err++; $display("FAIL back_to_back: got %h want 2222000211110001", rdata);
    end
  endtask

  task automatic test_bypass();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    idle();
    wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
    raddr = {5'd7, 5'd7};
    #1;
    n_cmp++;
    if (rdata !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      n_err++; $display("FAIL bypass_data: got %h want a5a5a5a5a5a5a5a5", rdata);
    end
    n_cmp++;
    if (rbusy !== 2'b00 || any_busy !== 1'b1) begin
      n_err++; $display("FAIL bypass_busy: got rbusy=%b any=%b want 00/1", rbusy, any_busy);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rdata[31:0] !== 32'hA5A5_A5A5 || rbusy !== 2'b00 || any_busy !== 1'b0) begin
      n_err++; $display("FAIL bypass_commit: got %h rbusy=%b any=%b want a5a5a5a5/00/0", rdata[31:0], rbusy, any_busy);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    raddr = {5'd5, 5'd3};
    iss_valid = 1'b1; iss_rd = 5'd3;
    #1;
    n_cmp++;
    if (rbusy !== 2'b00 || any_busy !== 1'b0) begin
      n_err++; $display("FAIL sb_issue_same_cycle: got rbusy=%b any=%b want 00/0", rbusy, any_busy);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rbusy !== 2'b01 || any_busy !== 1'b1) begin
      n_err++; $display("FAIL sb_set: got rbusy=%b any=%b want 01/1", rbusy, any_busy);
    end
    wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_0010;
    #1;
    n_cmp++;
    if (rbusy !== 2'b00 || rdata[31:0] !== 32'h10 || any_busy !== 1'b1) begin
      n_err++; $display("FAIL sb_wb_bypass: got rbusy=%b data=%h any=%b want 00/10/1", rbusy, rdata[31:0], any_busy);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rbusy !== 2'b00 || rdata[31:0] !== 32'h10 || any_busy !== 1'b0) begin
      n_err++; $display("FAIL sb_clear: got rbusy=%b data=%h any=%b want 00/10/0", rbusy, rdata[31:0], any_busy);
    end
  endtask

  task automatic test_collision();
    idle();
    raddr = {5'd0, 5'd9};
    iss_valid = 1'b1; iss_rd = 5'd9;
    wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rdata[31:0] !== 32'h99 || rbusy[0] !== 1'b1 || any_busy !== 1'b1) begin
      n_err++; $display("FAIL collision: got data=%h busy=%b any=%b want 99/1/1", rdata[31:0], rbusy[0], any_busy);
    end
    wen = 1'b1; waddr = 5'd9; wdata = 32'h0000_009A;
    tick();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    #1;
    n_cmp++;
    if (any_busy !== 1'b0 || rbusy !== 2'b00 || rdata[31:0] !== 32'h9A) begin
      n_err++; $display("FAIL issue_x0: got any=%b rbusy=%b data=%h want 0/00/9a", any_busy, rbusy, rdata[31:0]);
    end
  endtask

  task automatic test_flush();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_rd = 5'd6;
    tick();
    idle();
    raddr = {5'd6, 5'd4};
    #1;
    n_cmp++;
    if (rbusy !== 2'b11 || any_busy !== 1'b1) begin
      n_err++; $display("FAIL flush_pre: got rbusy=%b any=%b want 11/1", rbusy, any_busy);
    end
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd8;
    wen = 1'b1; waddr = 5'd4; wdata = 32'h0000_0044;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rbusy !== 2'b00 || any_busy !== 1'b0) begin
      n_err++; $display("FAIL flush_clear: got rbusy=%b any=%b want 00/0", rbusy, any_busy);
    end
    n_cmp++;
    if (rdata[31:0] !== 32'h44) begin
      n_err++; $display("FAIL flush_wb: got %h want 44", rdata[31:0]);
    end
    raddr = {5'd8, 5'd8};
    #1;
    n_cmp++;
    if (rbusy !== 2'b00) begin
      n_err++; $display("FAIL flush_issue_x8: got rbusy=%b want 00", rbusy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
